// File: rtl/adc_sched_pkg.sv
// -----------------------------------------------------------------------------
// adc_sched_pkg
// Shared definitions for the ADC acquisition sequencer (adc_sample_sched):
//   - default widths of the converted word, sample counter and period counter
//   - default minimum trigger spacing and conversion timeout
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package adc_sched_pkg;

   localparam int ADC_W_DEF       = 12;
   localparam int CNT_W_DEF       = 12;
   localparam int PER_W_DEF       = 16;
   localparam int MIN_PERIOD_DEF  = 40;
   localparam int TIMEOUT_CYC_DEF = 4095;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TRIG = 3'd1,
      WAIT = 3'd2,
      PACE = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/adc_period_timer.sv
// -----------------------------------------------------------------------------
// adc_period_timer
// Trigger-spacing down-counter. Holds the run period (clamped to MIN_PERIOD)
// and counts down from period-1 after every reload, stopping at zero.
//
// Ports:
//   clk_in  : system clock
//   rst     : asynchronous active-high reset
//   latch   : capture a new period from `period` (start cycle of a run)
//   period  : requested period in clk_in cycles
//   reload  : load the counter with period-1 (uses the incoming period when
//             latch is asserted in the same cycle)
//   en      : count down while the counter is non-zero
//   zero    : counter is at zero
// -----------------------------------------------------------------------------
module adc_period_timer #(
   parameter int PER_W      = 16,
   parameter int MIN_PERIOD = 40
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             latch,
   input  logic [PER_W-1:0] period,
   input  logic             reload,
   input  logic             en,
   output logic             zero
);

   logic [PER_W-1:0] per_q, per_d;
   logic [PER_W-1:0] cnt_q, cnt_d;
   logic [PER_W-1:0] per_eff;

   function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
      if (p < PER_W'(MIN_PERIOD)) begin
         return PER_W'(MIN_PERIOD);
      end
      return p;
   endfunction

   always_comb begin
      per_d   = per_q;
      cnt_d   = cnt_q;
      // The first trigger of a run is loaded in the same cycle the period is
      // latched, so the clamped input bypasses the register then.
      per_eff = latch ? clamp_period(period) : per_q;
      if (latch) begin
         per_d = per_eff;
      end
      if (reload) begin
         cnt_d = per_eff - 1'b1;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         per_q <= '0;
         cnt_q <= '0;
      end else begin
         per_q <= per_d;
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/adc_sample_sched.sv
// -----------------------------------------------------------------------------
// adc_sample_sched
// Acquisition sequencer in front of the serial ADC controller. Issues timed
// one-cycle conversion-start pulses, captures each converted word on the rising
// edge of adc_ready and presents it on a valid/ready stream. Counts samples per
// run, flags dropped samples (overrun) and conversions that never complete
// (timeout).
//
// Optional build macro ADC_SCHED_AVG_EN: every four completions are summed and
// one word (sum>>2) is produced; n_samples then counts output words.
//
// Ports:
//   clk_in    : system clock
//   rst       : asynchronous active-high reset
//   start     : one-cycle run request, ignored while busy
//   stop      : abort the current run
//   n_samples : samples per run, 0 = continuous until stop
//   period    : clk_in cycles between conversion starts (latched at start)
//   adc_ready : conversion-complete level from the ADC controller
//   adc_data  : converted word from the ADC controller
//   adc_ctrl  : one-cycle conversion-start pulse
//   out_data  : captured sample
//   out_valid : sample available
//   out_ready : consumer accepts sample
//   busy      : run in progress
//   done      : one-cycle end-of-run pulse
//   overrun   : sticky, a sample was dropped
//   timeout   : sticky, a conversion never completed
// -----------------------------------------------------------------------------
module adc_sample_sched
   import adc_sched_pkg::*;
#(
   parameter int ADC_W       = ADC_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int PER_W       = PER_W_DEF,
   parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] n_samples,
   input  logic [PER_W-1:0] period,
   input  logic             adc_ready,
   input  logic [ADC_W-1:0] adc_data,
   output logic             adc_ctrl,
   output logic [ADC_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   output logic             timeout
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] cnt_nxt;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             stop_pend_q, stop_pend_d;
   logic             adc_ready_q;
   logic [ADC_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q, overrun_d;
   logic             timeout_q, timeout_d;

   logic             comp;
   logic             word_ok;
   logic [ADC_W-1:0] word;
   logic             tmr_latch;
   logic             tmr_reload;
   logic             tmr_en;
   logic             tmr_zero;

`ifdef ADC_SCHED_AVG_EN
   localparam int ACC_W = ADC_W + 2;
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [1:0]       phase_q, phase_d;
`endif

   assign comp   = adc_ready & ~adc_ready_q;
   assign tmr_en = (state_q == TRIG) || (state_q == WAIT) || (state_q == PACE);

   adc_period_timer #(
      .PER_W      (PER_W),
      .MIN_PERIOD (MIN_PERIOD)
   ) u_timer (
      .clk_in (clk_in),
      .rst    (rst),
      .latch  (tmr_latch),
      .period (period),
      .reload (tmr_reload),
      .en     (tmr_en),
      .zero   (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      sample_cnt_d = sample_cnt_q;
      tmo_d        = tmo_q;
      stop_pend_d  = stop_pend_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      overrun_d    = overrun_q;
      timeout_d    = timeout_q;
      tmr_latch    = 1'b0;
      tmr_reload   = 1'b0;
      word_ok      = 1'b0;
      word         = adc_data;
      cnt_nxt      = sample_cnt_q + 1'b1;
`ifdef ADC_SCHED_AVG_EN
      acc_d        = acc_q;
      phase_d      = phase_q;
      acc_sum      = acc_q + ACC_W'(adc_data);
`endif

      // Consumer pop; a capture later in this block overrides it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               overrun_d    = 1'b0;
               timeout_d    = 1'b0;
               sample_cnt_d = '0;
               stop_pend_d  = 1'b0;
               n_d          = n_samples;
               tmr_latch    = 1'b1;
               tmr_reload   = 1'b1;
`ifdef ADC_SCHED_AVG_EN
               acc_d        = '0;
               phase_d      = '0;
`endif
               state_d      = TRIG;
            end
         end

         TRIG: begin
            tmo_d   = '0;
            state_d = stop ? DONE : WAIT;
         end

         WAIT: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (comp) begin
`ifdef ADC_SCHED_AVG_EN
               if (phase_q == 2'd3) begin
                  word_ok = 1'b1;
                  word    = acc_sum[ACC_W-1:2];
                  acc_d   = '0;
                  phase_d = '0;
               end else begin
                  acc_d   = acc_sum;
                  phase_d = phase_q + 2'd1;
               end
`else
               word_ok = 1'b1;
`endif
               if (word_ok) begin
                  sample_cnt_d = cnt_nxt;
                  // A word still waiting for the consumer is kept; the new
                  // one is dropped but still counted.
                  if (!out_valid_q || out_ready) begin
                     out_data_d  = word;
                     out_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
               if (stop || stop_pend_q ||
                   (word_ok && (n_q != '0) && (cnt_nxt == n_q))) begin
                  state_d = DONE;
               end else begin
                  state_d = PACE;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         PACE: begin
            if (stop) begin
               state_d = DONE;
            end else if (tmr_zero) begin
               tmr_reload = 1'b1;
               state_d    = TRIG;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         n_q          <= '0;
         sample_cnt_q <= '0;
         tmo_q        <= '0;
         stop_pend_q  <= 1'b0;
         adc_ready_q  <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         sample_cnt_q <= sample_cnt_d;
         tmo_q        <= tmo_d;
         stop_pend_q  <= stop_pend_d;
         adc_ready_q  <= adc_ready;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
      end
   end

`ifdef ADC_SCHED_AVG_EN
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         phase_q <= '0;
      end else begin
         acc_q   <= acc_d;
         phase_q <= phase_d;
      end
   end
`endif

   // Decoded from the state register so an asynchronous reset removes a
   // conversion-start pulse immediately.
   assign adc_ctrl  = (state_q == TRIG);
   assign done      = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_adc_sample_sched.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_sched
// Directed bench for adc_sample_sched. A small ADC controller model answers
// each adc_ctrl pulse by raising adc_ready 31 cycles later; conversion k of a
// run (k starting at 1) returns adc_base + k*adc_step.
// -----------------------------------------------------------------------------
module tb_adc_sample_sched;

   logic        clk_in;
   logic        rst;
   logic        start;
   logic        stop;
   logic [11:0] n_samples;
   logic [15:0] period;
   logic        adc_ready;
   logic [11:0] adc_data;
   logic        adc_ctrl;
   logic [11:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        overrun;
   logic        timeout;

   logic        adc_en;
   logic [11:0] adc_base;
   logic [11:0] adc_step;
   logic [11:0] conv_idx;
   int          adc_cnt;

   int          cyc = 0;
   int          trig_q[$];
   logic [11:0] beat_q[$];
   int          done_cnt = 0;
   int          done_cyc = 0;

   int          checks = 0;
   int          errors = 0;
   int          t0, b0, d0, k;

   adc_sample_sched dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .n_samples (n_samples),
      .period    (period),
      .adc_ready (adc_ready),
      .adc_data  (adc_data),
      .adc_ctrl  (adc_ctrl),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   assign adc_data = adc_base + adc_step * conv_idx;

   // ADC controller model
   always @(posedge clk_in or posedge rst) begin
      if (rst) begin
         adc_ready <= 1'b0;
         adc_cnt   <= -1;
         conv_idx  <= '0;
      end else begin
         if (start) conv_idx <= '0;
         if (adc_ctrl) begin
            adc_ready <= 1'b0;
            conv_idx  <= conv_idx + 12'd1;
            adc_cnt   <= adc_en ? 30 : -1;
         end else if (adc_cnt > 0) begin
            adc_cnt <= adc_cnt - 1;
         end else if (adc_cnt == 0) begin
            adc_ready <= 1'b1;
            adc_cnt   <= -1;
         end
      end
   end

   // Event recorder
   always @(negedge clk_in) begin
      if (adc_ctrl) trig_q.push_back(cyc);
      if (out_valid && out_ready) beat_q.push_back(out_data);
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic run_start();
      t0 = trig_q.size();
      b0 = beat_q.size();
      d0 = done_cnt;
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max) begin
         @(negedge clk_in);
         n++;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
      period = 16'd100; n_samples = 12'd3;
      adc_en = 1'b1; adc_base = '0; adc_step = '0;
      tick(3);
      chk("rst_adc_ctrl", adc_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b0;
      tick(2);

`ifndef ADC_SCHED_AVG_EN
      // 1: three samples, 100-cycle spacing
      adc_base = 12'hA5A; period = 16'd100; n_samples = 12'd3; out_ready = 1'b1;
      run_start();
      chk("t1_busy_rise", busy, 1);
      wait_done("t1_done_seen", 1000);
      tick(1);
      chk("t1_done_one_cycle", done, 0);
      chk("t1_busy_fall", busy, 0);
      tick(5);
      chk("t1_trig_count", trig_q.size() - t0, 3);
      chk("t1_spacing_01", trig_q[t0+1] - trig_q[t0], 100);
      chk("t1_spacing_12", trig_q[t0+2] - trig_q[t0+1], 100);
      chk("t1_beat_count", beat_q.size() - b0, 3);
      chk("t1_beat0", beat_q[b0], 12'hA5A);
      chk("t1_beat2", beat_q[b0+2], 12'hA5A);
      chk("t1_done_count", done_cnt - d0, 1);

      // 2: period below minimum is clamped to 40
      adc_base = 12'h3C3; period = 16'd10; n_samples = 12'd2;
      run_start();
      wait_done("t2_done_seen", 1000);
      tick(2);
      chk("t2_spacing", trig_q[t0+1] - trig_q[t0], 40);
      chk("t2_beat_count", beat_q.size() - b0, 2);

      // 3: consumer stalled, second sample dropped
      out_ready = 1'b0; adc_base = 12'h100; adc_step = 12'h011;
      period = 16'd40; n_samples = 12'd2;
      run_start();
      wait_done("t3_done_seen", 1000);
      tick(2);
      chk("t3_valid_held", out_valid, 1);
      chk("t3_first_word", out_data, 12'h111);
      chk("t3_overrun", overrun, 1);
      chk("t3_trig_count", trig_q.size() - t0, 2);
      out_ready = 1'b1;
      tick(1);
      chk("t3_valid_clear", out_valid, 0);
      adc_step = '0;

      // 4: conversion never completes
      adc_en = 1'b0; n_samples = 12'd1; period = 16'd40;
      run_start();
      wait_done("t4_done_seen", 5000);
      tick(1);
      chk("t4_timeout", timeout, 1);
      chk("t4_no_valid", out_valid, 0);
      chk("t4_overrun_cleared", overrun, 0);
      chk("t4_latency", done_cyc - trig_q[t0], 4097);
      chk("t4_beat_count", beat_q.size() - b0, 0);
      adc_en = 1'b1;

      // 5: continuous mode, stop during WAIT
      adc_base = 12'h5A5; n_samples = 12'd0; period = 16'd50;
      run_start();
      k = 0;
      while ((trig_q.size() - t0) < 2 && k < 500) begin
         @(negedge clk_in);
         k++;
      end
      chk("t5_second_trig", (trig_q.size() - t0) >= 2, 1);
      tick(10);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("t5_still_busy", busy, 1);
      wait_done("t5_done_seen", 500);
      tick(100);
      chk("t5_trig_count", trig_q.size() - t0, 2);
      chk("t5_beat_count", beat_q.size() - b0, 2);
      chk("t5_last_beat", beat_q[b0+1], 12'h5A5);
      chk("t5_idle", busy, 0);
`endif

      // 6: reset during PACE, reset during the trigger pulse, then a clean run
      adc_base = 12'h0AA; adc_step = '0; n_samples = 12'd3; period = 16'd100;
      out_ready = 1'b0;
      run_start();
      k = 0;
      while (out_valid !== 1'b1 && k < 600) begin
         @(negedge clk_in);
         k++;
      end
      chk("t6_first_word", out_valid, 1);
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_data", out_data, 0);
      chk("t6_rst_busy", busy, 0);
      @(negedge clk_in);
      rst = 1'b0;
      out_ready = 1'b1;
      tick(2);
      n_samples = 12'd1; period = 16'd40;
      run_start();
      chk("t6_ctrl_high", adc_ctrl, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_ctrl_dropped", adc_ctrl, 0);
      @(negedge clk_in);
      rst = 1'b0;
      tick(2);
      adc_base = 12'h7E7;
      run_start();
      wait_done("t6_done_seen", 600);
      tick(2);
      chk("t6_beat_count", beat_q.size() - b0, 1);
      chk("t6_beat", beat_q[b0], 12'h7E7);

`ifdef ADC_SCHED_AVG_EN
      // Averaging: 0x100..0x103 -> 0x101
      adc_base = 12'h0FF; adc_step = 12'h001; n_samples = 12'd1; period = 16'd40;
      run_start();
      wait_done("avg_done_seen", 1000);
      tick(2);
      chk("avg_trig_count", trig_q.size() - t0, 4);
      chk("avg_beat_count", beat_q.size() - b0, 1);
      chk("avg_beat", beat_q[b0], 12'h101);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
